aes_decrypt_core: RTL and testbench

- Iterative AES-128 inverse cipher (FIPS-197) that pairs with the encryption core behind the same SPI front end.
- Accepts the original cipher key and a 128-bit ciphertext, and returns the plaintext.
- Processes one round per clock.
- Runs a forward key expansion to reach round key 10, then regenerates round keys backwards on the fly, so no round-key RAM is needed.

---
 rtl/aes_pkg.sv | 113 +++++++++++
 rtl/aes_inv_sbox.sv | 11 +
 rtl/aes_decrypt_core.sv | 97 +++++++++
 tb/tb_aes_decrypt_core.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants, byte/word helpers and FSM encoding shared by the inverse cipher.
package aes_pkg;
    localparam int NR = 10;
    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;

    typedef enum logic [2:0] {IDLE, KEYEXP, ARK, ROUND, FINAL, DONE} fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return (x >> 1) ^ (x[0] ? 8'h8d : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    // Byte i of a block sits at [127-8i -: 8]; row r of column c is byte 4c+r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rcon, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo key_next: rcon must be the value that produced k.
    function automatic logic [127:0] key_prev(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        return {k[127:96] ^ sub_word(rot_word(p3)) ^ {rcon, 24'h0}, p1, p2, p3};
    endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational InvSubBytes over a full 16-byte block.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[8*i +: 8] = INV_SBOX[din[8*i +: 8]];
    end
endmodule

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 inverse cipher, one round per clock.
// Expands the key forward to round 10, then walks round keys back on the fly.
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic         int_osc,
    input  logic         nreset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] cyphertext,
    output logic         done,
    output logic [127:0] plaintext
);
    fsm_e         fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d, rk_q, rk_d, pt_q, pt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         load_q, done_q, done_d;
    logic [127:0] isb, imc;

    aes_inv_sbox u_inv_sbox (.din(inv_shift_rows(blk_q)), .dout(isb));

    assign imc       = inv_mix_columns(isb ^ rk_q);
    assign done      = done_q;
    assign plaintext = pt_q;

    always_comb begin
        fsm_d  = fsm_q;
        blk_d  = blk_q;
        rk_d   = rk_q;
        rcon_d = rcon_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        pt_d   = pt_q;
        if (fsm_q != IDLE && load) begin
            fsm_d  = IDLE;
            done_d = 1'b0;
        end else begin
            case (fsm_q)
                IDLE: if (load_q && !load) begin
                    blk_d  = cyphertext;
                    rk_d   = key;
                    rcon_d = RCON_FIRST;
                    cnt_d  = 4'd0;
                    fsm_d  = KEYEXP;
                end
                KEYEXP: begin
                    rk_d   = key_next(rk_q, rcon_q);
                    rcon_d = (rcon_q == RCON_LAST) ? rcon_q : xtime(rcon_q);
                    cnt_d  = (cnt_q == 4'(NR - 1)) ? cnt_q : cnt_q + 4'd1;
                    fsm_d  = (cnt_q == 4'(NR - 1)) ? ARK : KEYEXP;
                end
                ARK: begin
                    blk_d  = blk_q ^ rk_q;
                    rk_d   = key_prev(rk_q, rcon_q);
                    rcon_d = inv_xtime(rcon_q);
                    fsm_d  = ROUND;
                end
                ROUND: begin
                    blk_d  = imc;
                    rk_d   = key_prev(rk_q, rcon_q);
                    rcon_d = inv_xtime(rcon_q);
                    cnt_d  = (cnt_q == 4'd1) ? cnt_q : cnt_q - 4'd1;
                    fsm_d  = (cnt_q == 4'd1) ? FINAL : ROUND;
                end
                FINAL: begin
                    pt_d   = isb ^ rk_q;
                    done_d = 1'b1;
                    fsm_d  = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge int_osc or negedge nreset) begin
        if (!nreset) begin
            fsm_q  <= IDLE;
            blk_q  <= '0;
            rk_q   <= '0;
            pt_q   <= '0;
            rcon_q <= '0;
            cnt_q  <= '0;
            load_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            rk_q   <= rk_d;
            pt_q   <= pt_d;
            rcon_q <= rcon_d;
            cnt_q  <= cnt_d;
            load_q <= load;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb_aes_decrypt_core: scoreboard bench; a GF(2^8)-derived AES-128 encryptor produces
// ciphertexts whose plaintexts are queued and checked when done rises.
module tb_aes_decrypt_core;
    import aes_pkg::*;

    logic         int_osc = 1'b0;
    logic         nreset = 1'b0;
    logic         load = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] cyphertext = '0;
    logic         done;
    logic [127:0] plaintext;

    aes_decrypt_core dut (
        .int_osc(int_osc), .nreset(nreset), .load(load), .key(key),
        .cyphertext(cyphertext), .done(done), .plaintext(plaintext)
    );

    always #5 int_osc = ~int_osc;

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         e;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic         done_prev = 1'b0;
    logic [7:0]   tsbox [256];
    logic [127:0] last_pt = '0;

    always @(posedge int_osc) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge int_osc) begin
        if (nreset && done === 1'b1 && !done_prev) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done rose with nothing expected, plaintext %h (cycle %0d)", plaintext, cyc);
            end else begin
                e = sb_q.pop_front();
                check("plaintext", plaintext, e.pt);
                check("latency", 128'(cyc), 128'(e.due));
            end
        end
        done_prev = done;
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tsbox[tmp[23:16]], tsbox[tmp[15:8]], tsbox[tmp[7:0]], tsbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = tsbox[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++) begin
                {a0, a1, a2, a3} = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
                if (rnd < 10) begin
                    s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
                    s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
                end else begin
                    {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = {a0, a1, a2, a3};
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*rnd+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic tick();
        @(negedge int_osc);
    endtask

    // Pulse load for one cycle; capture happens on the edge after it drops.
    task automatic start(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt, input bit push);
        logic was_done;
        was_done = done;
        key = k;
        cyphertext = ct;
        load = 1'b1;
        tick();
        if (was_done) check("done_clear", 128'(done), 128'(0));
        load = 1'b0;
        if (push) sb_q.push_back('{pt, cyc + 22});
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) tick();
        tick();
        n_cmp++;
        if (sb_q.size() > 0) begin
            n_bad++;
            $display("FAIL timeout: done not seen, %0d results outstanding (cycle %0d)", sb_q.size(), cyc);
            sb_q.delete();
        end
    endtask

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10_2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    initial begin
        logic [127:0] rk, rp, rc;
        logic [7:0]   inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tsbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        repeat (3) tick();
        check("reset_done", 128'(done), 128'(0));
        check("reset_plaintext", plaintext, '0);
        nreset = 1'b1;
        repeat (2) tick();
        check("idle_no_start", 128'(done), 128'(0));

        start(K1, C1, P1, 1'b1);
        wait_done();
        repeat (5) tick();
        check("done_hold", 128'(done), 128'(1));
        check("hold_plaintext", plaintext, P1);

        start(K2, C2, P2, 1'b1);
        repeat (11) tick();
        check("rk_round10", dut.rk_q, RK10_2);
        repeat (10) tick();
        check("rk_round0", dut.rk_q, K2);
        wait_done();

        start(K1, C1, P1, 1'b0);
        repeat (15) tick();
        load = 1'b1;
        tick();
        check("abort_done", 128'(done), 128'(0));
        check("abort_idle", 128'(dut.fsm_q), 128'(IDLE));
        check("abort_plaintext_kept", plaintext, P2);
        start(K2, C2, P2, 1'b1);
        wait_done();

        start(K1, C1, P1, 1'b0);
        repeat (9) tick();
        #2 nreset = 1'b0;
        #1;
        check("areset_done", 128'(done), 128'(0));
        check("areset_plaintext", plaintext, '0);
        check("areset_idle", 128'(dut.fsm_q), 128'(IDLE));
        tick();
        nreset = 1'b1;
        repeat (30) tick();
        check("no_start_after_reset", 128'(done), 128'(0));

        for (int n = 0; n < 200; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            rc = encrypt(rk, rp);
            start(rk, rc, rp, 1'b1);
            wait_done();
            last_pt = rp;
        end
        repeat (4) tick();
        check("final_hold", plaintext, last_pt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
